// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Definitions shared by the router input FIFO, the per-output
//                arbiters and the LBDR routing logic: flit width, port
//                enumeration, default FIFO depth, flit type, write-side
//                handshake state encoding and a multi-hot helper.
//  Revision    : 1.0  initial release
// ============================================================================
package router_pkg;

  localparam int FLIT_WIDTH = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int NUM_PORTS  = 5;

  // Bit position of each port inside any per-port request/grant vector.
  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_W = 3'd2,
    PORT_S = 3'd3,
    PORT_L = 3'd4
  } port_e;

  typedef logic [FLIT_WIDTH-1:0] flit_t;

  // Ingress RTS/CTS handshake states.
  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_ACK  = 1'b1
  } wr_state_e;

  // True when more than one bit of a per-port vector is set.
  function automatic logic multi_hot(input logic [NUM_PORTS-1:0] v);
    return ($countones(v) > 1);
  endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : DEPTH x DATA_WIDTH register file with one synchronous write
//                port and one asynchronous read port. Storage is not reset.
//  Ports       : clk        - rising-edge clock
//                i_wr_en    - write strobe
//                i_wr_addr  - write index
//                i_wr_data  - write data
//                i_rd_addr  - read index
//                o_rd_data  - contents of entry i_rd_addr (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/router_input_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : router_input_fifo
//  Description : Input buffer for one router port. Accepts flits over the
//                RTS/CTS link handshake, stores them in a DEPTH-entry
//                circular FIFO, presents the head flit to the crossbar and
//                pops it when any output arbiter grants this input.
//  Ports       : clk           - rising-edge clock
//                rst           - asynchronous active-high reset
//                RX            - incoming flit, stable while DRTS=1
//                DRTS          - upstream request-to-send
//                CTS           - one-cycle clear-to-send pulse to upstream
//                read_en_N..L  - pop requests (arbiter grants)
//                Data_out      - head flit, valid when empty=0
//                empty / full  - occupancy flags
//                err_multi_rd  - sticky: more than one read_en in a cycle
//  Revision    : 1.0  initial release
// ============================================================================
module router_input_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  err_multi_rd
);

  localparam int               c_ADDR_W  = $clog2(DEPTH);
  localparam logic [c_ADDR_W:0] c_PTR_ONE = {{c_ADDR_W{1'b0}}, 1'b1};

  // Pointers carry one extra MSB that toggles on every wrap, so equal index
  // bits can be told apart as empty (same lap) or full (different lap).
  logic [c_ADDR_W:0]       r_wr_ptr;
  logic [c_ADDR_W:0]       r_rd_ptr;
  wr_state_e               r_state;
  logic                    r_cts;
  logic                    r_err_multi_rd;

  logic [NUM_PORTS-1:0]    w_rd_vec;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_wr;
  logic                    w_rd;
  logic [DATA_WIDTH-1:0]   w_head;

  // Bit order follows port_e (N at bit 0 ... L at bit 4).
  assign w_rd_vec = {read_en_L, read_en_S, read_en_W, read_en_E, read_en_N};

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]) &&
                   (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]);

  // Full is judged on the pre-pop occupancy: a flit offered while full waits
  // for the next IDLE cycle even if a pop happens on the same edge.
  assign w_wr = (r_state == WR_IDLE) && DRTS && !w_full;
  assign w_rd = (|w_rd_vec) && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= WR_IDLE;
      r_cts          <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_err_multi_rd <= 1'b0;
    end else begin
      // The ACK cycle gives the sender time to drop RTS before it is sampled
      // again, so a single RTS assertion never writes twice.
      case (r_state)
        WR_IDLE: begin
          if (w_wr) begin
            r_state <= WR_ACK;
            r_cts   <= 1'b1;
          end else begin
            r_cts   <= 1'b0;
          end
        end
        WR_ACK: begin
          r_state <= WR_IDLE;
          r_cts   <= 1'b0;
        end
        default: begin
          r_state <= WR_IDLE;
          r_cts   <= 1'b0;
        end
      endcase

      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      // Multiple grants still pop only one flit.
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (multi_hot(w_rd_vec)) begin
        r_err_multi_rd <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (c_ADDR_W)
  ) u_fifo_mem (
    .clk       (clk),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr[c_ADDR_W-1:0]),
    .i_wr_data (RX),
    .i_rd_addr (r_rd_ptr[c_ADDR_W-1:0]),
    .o_rd_data (w_head)
  );

  // Storage is not reset, so the head is forced to zero while nothing valid
  // is stored; this also gives Data_out a defined value out of reset.
  assign Data_out     = w_empty ? '0 : w_head;
  assign empty        = w_empty;
  assign full         = w_full;
  assign CTS          = r_cts;
  assign err_multi_rd = r_err_multi_rd;

endmodule : router_input_fifo
`default_nettype wire
